lcd_scanout: RTL and testbench

//  VRAM-to-display stage, downstream of the Z88 screen renderer. Reads the 640x64 1bpp

---
 rtl/lcd_scanout.sv | 102 ++++++++++
 tb/tb_lcd_scanout.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// Scans the 640x64 1bpp VRAM out as a 640x480@60 pixel stream, each LCD line shown 4x.
// Outputs trail the counters by one pix_ce; no backpressure, pacing is set by pix_ce.
module lcd_scanout #(
  parameter logic [11:0] ON_COLOR     = 12'h000,
  parameter logic [11:0] OFF_COLOR    = 12'hCDB,
  parameter logic [11:0] BORDER_COLOR = 12'h444,
  parameter int          V_TOP        = 112
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        pix_ce,
  input  logic        lcdon,
  output logic [13:0] vram_a,
  input  logic [3:0]  vram_di,
  output logic        hs_n,
  output logic        vs_n,
  output logic        de,
  output logic [11:0] rgb,
  output logic        fstart
);
  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic [9:0] H_ACT   = 10'd640;
  localparam logic [9:0] V_ACT   = 10'd480;
  localparam logic [9:0] H_SYNC0 = 10'd656;
  localparam logic [9:0] H_SYNC1 = 10'd752;
  localparam logic [9:0] V_SYNC0 = 10'd490;
  localparam logic [9:0] V_SYNC1 = 10'd492;
  localparam logic [9:0] H_PRE   = 10'd796;
  localparam logic [9:0] H_FEND  = 10'd636;
  localparam logic [9:0] WIN_LO  = 10'(V_TOP);
  localparam logic [9:0] WIN_HI  = 10'(V_TOP + 256);

  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic [3:0]  r_shift;
  logic [3:0]  r_next;
  logic        r_fetched;

  logic        w_hlast;
  logic        w_active;
  logic        w_pre;
  logic        w_cur_win;
  logic        w_frow_win;
  logic        w_fetch;
  logic [9:0]  w_vnext;
  logic [9:0]  w_frow;
  logic [5:0]  w_fline;
  logic [7:0]  w_fnib;
  logic [11:0] w_rgb;

  assign w_hlast   = (r_hcnt == H_LAST);
  assign w_vnext   = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
  assign w_active  = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_cur_win = (r_vcnt >= WIN_LO) && (r_vcnt < WIN_HI);

  // Near the end of each line the first nibble of the next row is prefetched.
  assign w_pre      = (r_hcnt == H_PRE);
  assign w_frow     = w_pre ? w_vnext : r_vcnt;
  assign w_frow_win = (w_frow >= WIN_LO) && (w_frow < WIN_HI);
  assign w_fline    = 6'((w_frow - WIN_LO) >> 2);
  assign w_fnib     = w_pre ? 8'd0 : r_hcnt[9:2] + 8'd1;
  assign w_fetch    = pix_ce && (r_hcnt[1:0] == 2'd0) && ((r_hcnt < H_FEND) || w_pre) && w_frow_win;

  assign w_rgb = !w_active            ? 12'h000 :
                 !w_cur_win           ? BORDER_COLOR :
                 (lcdon && r_shift[3]) ? ON_COLOR : OFF_COLOR;

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      r_hcnt    <= 10'd0;
      r_vcnt    <= 10'd0;
      r_shift   <= 4'd0;
      r_next    <= 4'd0;
      r_fetched <= 1'b0;
      vram_a    <= 14'd0;
      hs_n      <= 1'b1;
      vs_n      <= 1'b1;
      de        <= 1'b0;
      rgb       <= 12'h000;
      fstart    <= 1'b0;
    end else begin
      r_fetched <= w_fetch;
      fstart    <= pix_ce && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
      // Read data is valid the cycle after the address moves; pix_ce cannot fire in between.
      if (r_fetched)
        r_next <= vram_di;
      if (w_fetch)
        vram_a <= {w_fline, w_fnib};
      if (pix_ce) begin
        de      <= w_active;
        hs_n    <= !((r_hcnt >= H_SYNC0) && (r_hcnt < H_SYNC1));
        vs_n    <= !((r_vcnt >= V_SYNC0) && (r_vcnt < V_SYNC1));
        rgb     <= w_rgb;
        r_shift <= (r_hcnt[1:0] == 2'd3) ? r_next : {r_shift[2:0], 1'b0};
        r_hcnt  <= w_hlast ? 10'd0 : r_hcnt + 10'd1;
        if (w_hlast)
          r_vcnt <= w_vnext;
      end
    end
  end
endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: position-based reference model checked every mck plus literal spot checks.
module tb_lcd_scanout;
  localparam int VT = 3;
  localparam logic [11:0] ON_C  = 12'h000;
  localparam logic [11:0] OFF_C = 12'hCDB;
  localparam logic [11:0] BRD_C = 12'h444;

  logic        mck    = 1'b0;
  logic        rin_n  = 1'b0;
  logic        pix_ce = 1'b0;
  logic        lcdon  = 1'b0;
  logic [13:0] vram_a;
  logic [3:0]  vram_di;
  logic        hs_n;
  logic        vs_n;
  logic        de;
  logic [11:0] rgb;
  logic        fstart;

  logic [3:0]  mem [0:16383];
  assign vram_di = mem[vram_a];

  always #5 mck = ~mck;

  lcd_scanout #(.V_TOP(VT)) dut (
    .mck     (mck),
    .rin_n   (rin_n),
    .pix_ce  (pix_ce),
    .lcdon   (lcdon),
    .vram_a  (vram_a),
    .vram_di (vram_di),
    .hs_n    (hs_n),
    .vs_n    (vs_n),
    .de      (de),
    .rgb     (rgb),
    .fstart  (fstart)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int scen   = 0;
  logic ce_run = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic in_win(input int row);
    return (row >= VT) && (row < VT + 256);
  endfunction

  function automatic logic [11:0] exp_pixel(input int h, input int v);
    logic [3:0] nib;
    if (!(h < 640 && v < 480)) return 12'h000;
    if (!in_win(v)) return BRD_C;
    if (!lcdon) return OFF_C;
    nib = mem[14'(((v - VT) / 4) * 256 + h / 4)];
    return nib[3 - (h % 4)] ? ON_C : OFF_C;
  endfunction

  // Reference model: the n-th pix_ce after reset shows screen position n mod 420000.
  logic        mdl_ok = 1'b0;
  int          n_ce   = 0;
  logic        exp_hs, exp_vs, exp_de, exp_fs;
  logic [11:0] exp_rgb;
  logic [13:0] exp_va;
  int          out_h, out_v;
  logic        out_new = 1'b0;

  always @(posedge mck) begin
    int p, h, v, row;
    out_new <= 1'b0;
    exp_fs  <= 1'b0;
    if (!rin_n) begin
      mdl_ok  <= 1'b1;
      n_ce    <= 0;
      exp_hs  <= 1'b1;
      exp_vs  <= 1'b1;
      exp_de  <= 1'b0;
      exp_rgb <= 12'h000;
      exp_va  <= 14'd0;
    end else if (pix_ce) begin
      p = n_ce % 420000;
      h = p % 800;
      v = p / 800;
      exp_de  <= (h < 640) && (v < 480);
      exp_hs  <= !((h >= 656) && (h < 752));
      exp_vs  <= !((v >= 490) && (v < 492));
      exp_rgb <= exp_pixel(h, v);
      exp_fs  <= (p == 0);
      if ((h % 4 == 0) && ((h < 636) || (h == 796))) begin
        row = (h == 796) ? (v + 1) % 525 : v;
        if (in_win(row))
          exp_va <= 14'(((row - VT) / 4) * 256 + ((h + 4) % 800) / 4);
      end
      out_h   <= h;
      out_v   <= v;
      out_new <= 1'b1;
      n_ce    <= n_ce + 1;
    end
  end

  int hs_low = 0;
  int de_cnt = 0;

  always @(negedge mck) begin
    if (mdl_ok) begin
      check("hs_n", 32'(hs_n), 32'(exp_hs));
      check("vs_n", 32'(vs_n), 32'(exp_vs));
      check("de", 32'(de), 32'(exp_de));
      check("rgb", 32'(rgb), 32'(exp_rgb));
      check("fstart", 32'(fstart), 32'(exp_fs));
      check("vram_a", 32'(vram_a), 32'(exp_va));
      if (out_new) begin
        if (out_h == 0) begin
          hs_low = 0;
          de_cnt = 0;
        end
        if (!hs_n) hs_low++;
        if (de) de_cnt++;
        if (out_h == 799) begin
          check("hs_low_per_line", 32'(hs_low), 32'd96);
          if (out_v < 480) check("de_per_line", 32'(de_cnt), 32'd640);
        end
        if (out_h == 0 && out_v == 0) check("fstart_at_origin", 32'(fstart), 32'd1);
        if (scen == 1) begin
          if ((out_v == VT || out_v == VT + 3) && out_h < 4)
            check("lit_1010_px", 32'(rgb), 32'((out_h % 2 == 0) ? ON_C : OFF_C));
          if (out_v == VT + 4 && out_h < 4) check("lit_F_px", 32'(rgb), 32'(ON_C));
          if (out_v == 0 && out_h < 640) check("lit_border_row0", 32'(rgb), 32'(BRD_C));
          if (out_v == VT - 1 && out_h == 796) check("lit_prefetch_a", 32'(vram_a), 32'h0000);
          if (out_v == VT && out_h == 0) check("lit_fetch_nib1", 32'(vram_a), 32'h0001);
          if (out_v == VT + 3 && out_h == 796) check("lit_fetch_line1", 32'(vram_a), 32'h0100);
        end
        if (scen == 2 && out_v == VT + 1 && out_h == 5)
          check("lit_lcdoff_px", 32'(rgb), 32'(OFF_C));
      end
    end
  end

  initial begin
    forever begin
      @(negedge mck);
      pix_ce = ce_run ? !pix_ce : 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 4'd0;
    rin_n = 1'b0;
    repeat (3) @(negedge mck);
    check("rst_hs_n", 32'(hs_n), 32'd1);
    check("rst_vs_n", 32'(vs_n), 32'd1);
    check("rst_de", 32'(de), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_vram_a", 32'(vram_a), 32'd0);
    check("rst_fstart", 32'(fstart), 32'd0);

    for (int i = 0; i < 3 * 256; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[14'h0000] = 4'b1010;
    mem[14'h0100] = 4'hF;
    lcdon = 1'b1;
    scen  = 1;
    rin_n = 1'b1;
    repeat (12 * 1600) @(negedge mck);

    rin_n = 1'b0;
    scen  = 2;
    lcdon = 1'b0;
    for (int i = 0; i < 4 * 256; i++) mem[i] = 4'hF;
    repeat (3) @(negedge mck);
    rin_n = 1'b1;
    repeat (5 * 1600 + 700) @(negedge mck);

    rin_n = 1'b0;
    repeat (2) @(negedge mck);
    scen = 3;
    for (int i = 0; i < 3 * 256; i++) mem[i] = 4'($urandom_range(0, 15));
    lcdon = 1'b1;
    rin_n = 1'b1;
    repeat (10 * 1600) @(negedge mck);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
